// File: rtl/dmem_slow.sv
// -----------------------------------------------------------------------------
// dmem_slow
//   Multi-cycle single-port word RAM behind a request/done handshake. A read
//   and/or write request is latched, a counter runs for LATENCY cycles, the
//   access is performed (write first, then read), and done pulses for a single
//   cycle so the pipeline can release its stall.
//
// Parameters
//   DATA_W   word width in bits (multiple of 8)
//   ADDR_W   word-index bits, depth = 2**ADDR_W
//   LATENCY  cycles from acceptance to done, 1..255
//
// Ports
//   CLK          clock, rising edge
//   RST          synchronous active-low reset
//   ReadEnable   read request
//   WriteEnable  write request
//   Address      byte address, word index = Address[ADDR_W+1:2]
//   WriteData    write data
//   ByteEnable   per-byte write mask (used only with DMEM_SLOW_BYTEWRITE_EN)
//   ReadData     read result, held until the next completed read
//   done         single-cycle completion pulse
//   busy         high while a request is in flight
//
// Build option
//   DMEM_SLOW_BYTEWRITE_EN  defined: writes update only enabled byte lanes;
//                           undefined: every write updates the full word.
// -----------------------------------------------------------------------------
module dmem_slow #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 7,
    parameter int LATENCY = 20
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ReadEnable,
    input  logic                WriteEnable,
    input  logic [31:0]         Address,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [DATA_W/8-1:0] ByteEnable,
    output logic [DATA_W-1:0]   ReadData,
    output logic                done,
    output logic                busy
);

    localparam int         NB  = DATA_W / 8;
    localparam logic [7:0] LAT = 8'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state;
    logic [7:0]          cnt;
    logic                cap_re;
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_idx;
    logic [DATA_W-1:0]   cap_wdata;
`ifdef DMEM_SLOW_BYTEWRITE_EN
    logic [NB-1:0]       cap_be;
`endif

    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic                req;
    logic                fire;
    logic [DATA_W-1:0]   wr_word;

    // Byte offset and upper address bits are ignored: addresses alias modulo depth.
    logic unused_addr;
    assign unused_addr = ^{Address[31:ADDR_W+2], Address[1:0]};
`ifndef DMEM_SLOW_BYTEWRITE_EN
    logic unused_be;
    assign unused_be = ^ByteEnable;
`endif

    assign req  = ReadEnable | WriteEnable;
    // Access happens on the edge that ends the last BUSY cycle.
    assign fire = (state == S_BUSY) && (cnt == LAT);

    // Word as it will look after the write; also what a combined
    // write+read returns, so unmasked old bytes are included.
    always_comb begin
`ifdef DMEM_SLOW_BYTEWRITE_EN
        wr_word = mem[cap_idx];
        for (int i = 0; i < NB; i++) begin
            if (cap_be[i]) wr_word[8*i +: 8] = cap_wdata[8*i +: 8];
        end
`else
        wr_word = cap_wdata;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            ReadData  <= '0;
            cap_re    <= 1'b0;
            cap_we    <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
`ifdef DMEM_SLOW_BYTEWRITE_EN
            cap_be    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // DONE accepts a new request exactly like IDLE, giving
                    // one access per LATENCY+1 cycles when held.
                    done <= 1'b0;
                    if (req) begin
                        cap_re    <= ReadEnable;
                        cap_we    <= WriteEnable;
                        cap_idx   <= Address[ADDR_W+1:2];
                        cap_wdata <= WriteData;
`ifdef DMEM_SLOW_BYTEWRITE_EN
                        cap_be    <= ByteEnable;
`endif
                        cnt       <= 8'd1;
                        busy      <= 1'b1;
                        state     <= S_BUSY;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    // Inputs are ignored here; the captured request completes.
                    if (fire) begin
                        if (cap_re) ReadData <= cap_we ? wr_word : mem[cap_idx];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset so it maps onto plain memory; only the
    // write strobe is gated by RST so a reset aborts an in-flight write.
    always_ff @(posedge CLK) begin
        if (RST && fire && cap_we) mem[cap_idx] <= wr_word;
    end

endmodule

// File: tb/tb_dmem_slow.sv
module tb_dmem_slow;

    localparam int L_A = 20;
    localparam int L_B = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        re_a, we_a, re_b, we_b;
    logic [31:0] addr_a, wd_a, addr_b, wd_b;
    logic [3:0]  be_a, be_b;
    logic [31:0] rd_a, rd_b;
    logic        done_a, busy_a, done_b, busy_b;

    dmem_slow #(.DATA_W(32), .ADDR_W(7), .LATENCY(L_A)) u_dut_a (
        .CLK(CLK), .RST(RST), .ReadEnable(re_a), .WriteEnable(we_a),
        .Address(addr_a), .WriteData(wd_a), .ByteEnable(be_a),
        .ReadData(rd_a), .done(done_a), .busy(busy_a)
    );

    dmem_slow #(.DATA_W(32), .ADDR_W(7), .LATENCY(L_B)) u_dut_b (
        .CLK(CLK), .RST(RST), .ReadEnable(re_b), .WriteEnable(we_b),
        .Address(addr_b), .WriteData(wd_b), .ByteEnable(be_b),
        .ReadData(rd_b), .done(done_b), .busy(busy_b)
    );

    typedef struct {
        int          cyc;
        logic [31:0] rd;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit stream_b = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (word array, abstract) ----------------
    logic [31:0] mem_m [128];
    logic [31:0] last_rd_a = '0;

    function automatic logic [31:0] apply_write(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = old;
`ifdef DMEM_SLOW_BYTEWRITE_EN
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
`else
        r = wd;
`endif
        return r;
    endfunction

    // ---------------- monitors ----------------
    logic prev_done_a = 1'b0;
    always @(posedge CLK) begin
        #1;
        if (RST) begin
            check("busy_done_excl_a", {31'b0, busy_a & done_a}, 32'd0);
            if (done_a) begin
                check("done_consecutive_a", {31'b0, prev_done_a}, 32'd0);
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done_a: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    e_a = q_a.pop_front();
                    check("done_cycle_a", 32'(cyc), 32'(e_a.cyc));
                    check("read_data_a", rd_a, e_a.rd);
                end
            end else if (q_a.size() > 0) begin
                if (cyc > q_a[0].cyc) begin
                    checks++; errors++;
                    $display("FAIL missing_done_a: got done=0 expected done=1 at cycle %0d", q_a[0].cyc);
                    void'(q_a.pop_front());
                end else begin
                    check("busy_inflight_a", {31'b0, busy_a}, 32'd1);
                end
            end
        end
        prev_done_a = done_a;
    end

    logic prev_done_b = 1'b0;
    always @(posedge CLK) begin
        #1;
        if (RST) begin
            check("busy_done_excl_b", {31'b0, busy_b & done_b}, 32'd0);
            if (stream_b) check("busy_not_done_b", {31'b0, busy_b}, {31'b0, ~done_b});
            if (done_b) begin
                check("done_consecutive_b", {31'b0, prev_done_b}, 32'd0);
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done_b: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    e_b = q_b.pop_front();
                    check("done_cycle_b", 32'(cyc), 32'(e_b.cyc));
                    check("read_data_b", rd_b, e_b.rd);
                end
            end else if (q_b.size() > 0 && cyc > q_b[0].cyc) begin
                checks++; errors++;
                $display("FAIL missing_done_b: got done=0 expected done=1 at cycle %0d", q_b[0].cyc);
                void'(q_b.pop_front());
            end
        end
        prev_done_b = done_b;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_empty_a();
        for (int t = 0; t < L_A + 10 && q_a.size() != 0; t++) begin
            @(posedge CLK); #2;
        end
        if (q_a.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout_a: got %0d pending expected 0 pending", q_a.size());
            q_a.delete();
        end
    endtask

    // Issue one request on dut A; enables stay high for 'hold' edges after
    // acceptance (ignored while BUSY), then drop before the DONE cycle.
    task automatic req_a(input logic re, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input int hold);
        int   idx;
        exp_t e;
        idx = int'(addr[8:2]);
        @(negedge CLK);
        re_a = re; we_a = we; addr_a = addr; wd_a = wd; be_a = be;
        @(posedge CLK); #2;
        if (we) mem_m[idx] = apply_write(mem_m[idx], wd, be);
        if (re) last_rd_a = mem_m[idx];
        e.cyc = cyc + L_A;
        e.rd  = last_rd_a;
        q_a.push_back(e);
        repeat (hold) @(posedge CLK);
        @(negedge CLK);
        re_a = 1'b0; we_a = 1'b0; addr_a = $urandom; wd_a = $urandom; be_a = 4'($urandom);
        wait_empty_a();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        exp_t        e;
        int          c0;
        logic [31:0] a;
        RST = 1'b0;
        re_a = 0; we_a = 0; addr_a = 0; wd_a = 0; be_a = 0;
        re_b = 0; we_b = 0; addr_b = 0; wd_b = 0; be_b = 0;
        repeat (3) @(posedge CLK);
        #2;
        check("reset_done_a", {31'b0, done_a}, 32'd0);
        check("reset_busy_a", {31'b0, busy_a}, 32'd0);
        check("reset_rd_a",   rd_a, 32'd0);
        check("reset_rd_b",   rd_b, 32'd0);
        @(negedge CLK); RST = 1'b1;

        // Reset mid-operation: 0x40 holds a known value, the aborted write must not land.
        req_a(1'b0, 1'b1, 32'h40, 32'h1111_1111, 4'hF, 0);
        @(negedge CLK); we_a = 1'b1; addr_a = 32'h40; wd_a = 32'hDEAD_BEEF; be_a = 4'hF;
        @(posedge CLK); #2;
        repeat (9) @(posedge CLK);
        @(negedge CLK); RST = 1'b0; we_a = 1'b0;
        @(posedge CLK); #2;
        check("abort_done", {31'b0, done_a}, 32'd0);
        check("abort_busy", {31'b0, busy_a}, 32'd0);
        check("abort_rd",   rd_a, 32'd0);
        last_rd_a = '0;
        repeat (25) begin
            @(posedge CLK); #2;
            check("abort_no_done", {31'b0, done_a}, 32'd0);
        end
        @(negedge CLK); RST = 1'b1;
        req_a(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0);
        check("abort_no_write", {31'b0, rd_a == 32'hDEAD_BEEF}, 32'd0);

        // Basic latency, dropped enable, aliasing.
        req_a(1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 0);
        req_a(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        check("basic_read", rd_a, 32'h1234_5678);
        req_a(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1);
        req_a(1'b1, 1'b0, 32'h210, 32'h0, 4'h0, 0);
        check("alias_read", rd_a, 32'h1234_5678);

        // Simultaneous write+read, then byte-lane write and readback.
        req_a(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 0);
        check("wr_rd_same", rd_a, 32'hCAFE_F00D);
        req_a(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0);
        check("write_only_keeps_rd", rd_a, 32'hCAFE_F00D);
        req_a(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0);
`ifdef DMEM_SLOW_BYTEWRITE_EN
        check("byte_lane", rd_a, 32'hCABB_F0DD);
`else
        check("byte_lane", rd_a, 32'hAABB_CCDD);
`endif

        // Randomised traffic over eight preloaded words with aliased addresses.
        for (int i = 0; i < 8; i++)
            req_a(1'b0, 1'b1, 32'(32 * i + 256), $urandom, 4'hF, 0);
        for (int n = 0; n < 30; n++) begin
            logic [1:0] op;
            op = 2'($urandom_range(2, 0));
            a  = {$urandom, 2'b00};
            a[8:2] = 7'(8 * $urandom_range(7, 0) + 64);
            a[1:0] = 2'($urandom);
            req_a(op != 2'd1, op != 2'd0, a, $urandom, 4'($urandom), $urandom_range(L_A - 1, 0));
        end

        // Back-to-back on the LATENCY=3 instance: preload, then hold ReadEnable.
        @(negedge CLK); we_b = 1'b1; addr_b = 32'h8; wd_b = 32'h5A5A_1234; be_b = 4'hF;
        @(posedge CLK); #2;
        e.cyc = cyc + L_B; e.rd = 32'h0; q_b.push_back(e);
        @(negedge CLK); we_b = 1'b0;
        for (int t = 0; t < 10 && q_b.size() != 0; t++) begin @(posedge CLK); #2; end
        @(negedge CLK); re_b = 1'b1;
        @(posedge CLK); #2;
        c0 = cyc;
        stream_b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e.cyc = c0 + L_B + k * (L_B + 1); e.rd = 32'h5A5A_1234; q_b.push_back(e);
        end
        for (int t = 0; t < 40 && q_b.size() != 0; t++) begin @(posedge CLK); #2; end
        if (q_b.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout_b: got %0d pending expected 0 pending", q_b.size());
            q_b.delete();
        end
        @(negedge CLK); re_b = 1'b0; stream_b = 1'b0;
        repeat (6) @(posedge CLK);
        #2;
        check("b_idle_after_stream", {31'b0, busy_b}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
